signal_cfg_writer: RTL and testbench
====================================

SIGNAL_CFG_WRITER -- requirements
Module: signal_cfg_writer

Interface
REQ-001 Parameter NUM_WORDS, default 26, is the number of 32-bit configuration words; NUM_WORDS x WORD_WIDTH is the width of cfg_data.
REQ-002 Parameter WORD_WIDTH, default 32, is the width of each configuration word in bits.
REQ-003 Port aclk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port aresetn  input  1  reset; asynchronous, active-low.
REQ-005 Port wr_valid  input  1  write request.
REQ-006 Port wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-007 Port wr_addr  input  5  word index.
REQ-008 Port wr_data  input  32  write data.
REQ-009 Port wr_strb  input  4  byte enables; bit i selects wr_data[8i+7:8i].
REQ-010 Port wr_err  output  1  one-cycle pulse for an accepted write with wr_addr >= NUM_WORDS.
REQ-011 Port sync_mode  input  1  0 = apply on commit; 1 = apply on update_tick.
REQ-012 Port commit_req  input  1  single-cycle request to publish the shadow bank.
REQ-013 Port commit_abort  input  1  cancels a pending commit.
REQ-014 Port update_tick  input  1  period-boundary strobe from the DDS.
REQ-015 Port cfg_data  output  832  active configuration bus; word k drives bits [32k+31:32k].
REQ-016 Port cfg_update  output  1  one-cycle pulse in the cycle cfg_data first shows new contents.
REQ-017 Port pending  output  1  high while in state PENDING.
REQ-018 Port apply_count  output  16  number of completed applies; wraps 0xFFFF -> 0.
REQ-019 Port rd_addr  input  5  readback word index.
REQ-020 Port rd_sel  input  1  0 = read active bank; 1 = read shadow bank.
REQ-021 Port rd_data  output  32  readback data.

Function
REQ-022 The block SHALL hold two banks of NUM_WORDS words: shadow (written by the write port) and active (drives cfg_data).
REQ-023 The state machine SHALL have three states: IDLE, PENDING, APPLY.
REQ-024 wr_ready SHALL be high in IDLE and low in PENDING and APPLY.
REQ-025 On an accepted write to an in-range address, the shadow word SHALL update only the enabled bytes, visible in shadow readback on the next cycle.
REQ-026 On an accepted write to an out-of-range address, no bank SHALL change, and wr_err SHALL pulse on the next cycle.
REQ-027 If commit_req is high in IDLE, the state SHALL go to APPLY when sync_mode=0 and to PENDING when sync_mode=1.
REQ-028 A write accepted in the same cycle as commit_req SHALL be included in the commit.
REQ-029 In PENDING, the first update_tick strictly after entry SHALL move the state to APPLY; a tick in the same cycle as commit_req SHALL NOT trigger an apply.
REQ-030 In PENDING, commit_abort SHALL return the state to IDLE with no apply; commit_abort SHALL take priority over a simultaneous update_tick.
REQ-031 In APPLY, all active words SHALL be loaded from shadow in one cycle, apply_count SHALL increment, and the state SHALL return to IDLE.
REQ-032 cfg_update SHALL pulse in the cycle after APPLY, together with the new cfg_data.
REQ-033 In PENDING and APPLY, commit_req SHALL be ignored; commit_abort outside PENDING SHALL be ignored.
REQ-034 Worst-case latency from commit_req (sync_mode=0) to cfg_update SHALL be 2 cycles.
REQ-035 rd_data SHALL be registered with 1-cycle latency, and SHALL return 0 for rd_addr >= NUM_WORDS.

Reset
REQ-036 Asserting aresetn low SHALL, asynchronously, set both banks to 0, state to IDLE, and wr_ready, wr_err, cfg_update, pending, apply_count and rd_data to 0.
REQ-037 wr_ready SHALL rise in the first clock after aresetn deasserts.
REQ-038 Reset in PENDING or APPLY SHALL discard the pending commit with no cfg_update pulse.

Structure
REQ-039 Package signal_cfg_pkg SHALL hold NUM_WORDS, WORD_WIDTH, CFG_WIDTH (832) and the state encoding.
REQ-040 The shadow bank with byte-strobe write logic SHALL be a sub-module, signal_cfg_bank; the active bank and FSM SHALL live in the top module.

Verification
REQ-041 Write 0x12345678 to word 0 (strb 0xF), commit with sync_mode=0 -> cfg_update 2 cycles after commit_req; cfg_data[31:0]=0x12345678; apply_count=1.
REQ-042 sync_mode=1: write word 3 = 0xAAAA5555, commit, tick after 10 cycles -> pending high for 10 cycles; cfg_data[127:96] unchanged until the cycle after APPLY; wr_ready low while pending.
REQ-043 Write word 1 = 0xFFFFFFFF, then word 1 = 0x00000000 with strb 0x2 -> shadow readback 0xFFFF00FF after 1 cycle; active readback still 0.
REQ-044 Write to wr_addr 26 -> wr_err one-cycle pulse; all banks unchanged.
REQ-045 commit_abort and update_tick together in PENDING -> IDLE, no cfg_update; also assert aresetn low in PENDING -> cfg_data=0 and no pulse.
REQ-046 65536 commits -> apply_count wraps to 0.

Source files
------------

// File: rtl/signal_cfg_pkg.sv
// Shared definitions for the signal configuration writer.
// Holds the bank geometry and the FSM state encoding.
package signal_cfg_pkg;

    localparam int NUM_WORDS  = 26;
    localparam int WORD_WIDTH = 32;
    localparam int CFG_WIDTH  = NUM_WORDS * WORD_WIDTH;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/signal_cfg_bank.sv
// Shadow configuration bank with byte-strobe writes.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears all words)
//   we          - write enable (caller guarantees addr is in range)
//   addr        - word index
//   data, strb  - write data and per-byte enables
//   words       - whole bank, word k at bits [k*WORD_WIDTH +: WORD_WIDTH]
module signal_cfg_bank #(
    parameter int NUM_WORDS  = signal_cfg_pkg::NUM_WORDS,
    parameter int WORD_WIDTH = signal_cfg_pkg::WORD_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [signal_cfg_pkg::ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0]             data,
    input  logic [WORD_WIDTH/8-1:0]           strb,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]   words
);
    import signal_cfg_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else if (we) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (addr == ADDR_WIDTH'(k)) begin
                    for (int b = 0; b < WORD_WIDTH/8; b++) begin
                        if (strb[b]) begin
                            words[k*WORD_WIDTH + b*8 +: 8] <= data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/signal_cfg_writer.sv
// Double-buffered configuration writer.
// Writes land in a shadow bank; a commit copies the whole shadow bank into
// the active bank (cfg_data) in one cycle, either immediately or on the next
// DDS period boundary (update_tick).
// Ports:
//   aclk, aresetn                 - clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/
//   wr_data/wr_strb/wr_err        - shadow write port, error pulse for bad address
//   sync_mode, commit_req,
//   commit_abort, update_tick     - commit control
//   cfg_data, cfg_update          - active bank and its one-cycle update pulse
//   pending, apply_count          - status
//   rd_addr, rd_sel, rd_data      - registered readback (rd_sel 1 = shadow)
//
// state   | meaning
// IDLE    | accepting writes, waiting for commit_req
// PENDING | commit armed, waiting for update_tick (or commit_abort)
// APPLY   | copying shadow into active this cycle
module signal_cfg_writer #(
    parameter int NUM_WORDS  = signal_cfg_pkg::NUM_WORDS,
    parameter int WORD_WIDTH = signal_cfg_pkg::WORD_WIDTH
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [signal_cfg_pkg::ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0]                 wr_data,
    input  logic [WORD_WIDTH/8-1:0]               wr_strb,
    output logic                                  wr_err,
    input  logic                                  sync_mode,
    input  logic                                  commit_req,
    input  logic                                  commit_abort,
    input  logic                                  update_tick,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]       cfg_data,
    output logic                                  cfg_update,
    output logic                                  pending,
    output logic [15:0]                           apply_count,
    input  logic [signal_cfg_pkg::ADDR_WIDTH-1:0] rd_addr,
    input  logic                                  rd_sel,
    output logic [WORD_WIDTH-1:0]                 rd_data
);
    import signal_cfg_pkg::*;

    cfg_state_t                     state, state_nxt;
    logic                           wr_fire;
    logic                           wr_in_range;
    logic [NUM_WORDS*WORD_WIDTH-1:0] shadow;
    logic [NUM_WORDS*WORD_WIDTH-1:0] active;
    logic [15:0]                    apply_cnt;
    logic [WORD_WIDTH-1:0]          rd_word;

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = 32'(wr_addr) < NUM_WORDS;

    signal_cfg_bank #(
        .NUM_WORDS  (NUM_WORDS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_shadow (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (wr_fire && wr_in_range),
        .addr  (wr_addr),
        .data  (wr_data),
        .strb  (wr_strb),
        .words (shadow)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A tick arriving with commit_req is seen while still in IDLE and is
    // therefore ignored; only ticks seen in PENDING can trigger the apply.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_req) state_nxt = sync_mode ? PENDING : APPLY;
            PENDING: begin
                if (commit_abort)     state_nxt = IDLE;
                else if (update_tick) state_nxt = APPLY;
            end
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (rd_addr == ADDR_WIDTH'(k)) begin
                rd_word = rd_sel ? shadow[k*WORD_WIDTH +: WORD_WIDTH]
                                 : active[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // wr_ready follows the next state so it is already low during APPLY,
    // which keeps the shadow bank stable while it is being copied.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ready   <= 1'b0;
            wr_err     <= 1'b0;
            cfg_update <= 1'b0;
            active     <= '0;
            apply_cnt  <= '0;
            rd_data    <= '0;
        end else begin
            wr_ready   <= (state_nxt == IDLE);
            wr_err     <= wr_fire && !wr_in_range;
            cfg_update <= (state == APPLY);
            rd_data    <= rd_word;
            if (state == APPLY) begin
                active    <= shadow;
                apply_cnt <= apply_cnt + 16'd1;
            end
        end
    end

    assign cfg_data    = active;
    assign apply_count = apply_cnt;
    assign pending     = (state == PENDING);

endmodule

// File: tb/tb_signal_cfg_writer.sv
module tb_signal_cfg_writer;
    import signal_cfg_pkg::*;

    logic                   aclk;
    logic                   aresetn;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [4:0]             wr_addr;
    logic [31:0]            wr_data;
    logic [3:0]             wr_strb;
    logic                   wr_err;
    logic                   sync_mode;
    logic                   commit_req;
    logic                   commit_abort;
    logic                   update_tick;
    logic [CFG_WIDTH-1:0]   cfg_data;
    logic                   cfg_update;
    logic                   pending;
    logic [15:0]            apply_count;
    logic [4:0]             rd_addr;
    logic                   rd_sel;
    logic [31:0]            rd_data;

    int passed = 0;
    int total  = 0;

    signal_cfg_writer dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .wr_err       (wr_err),
        .sync_mode    (sync_mode),
        .commit_req   (commit_req),
        .commit_abort (commit_abort),
        .update_tick  (update_tick),
        .cfg_data     (cfg_data),
        .cfg_update   (cfg_update),
        .pending      (pending),
        .apply_count  (apply_count),
        .rd_addr      (rd_addr),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_word(input logic sel, input logic [4:0] a, output logic [31:0] d);
        rd_sel  = sel;
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        sync_mode = 1'b0; commit_req = 1'b0; commit_abort = 1'b0; update_tick = 1'b0;
        rd_addr = '0; rd_sel = 1'b0;
        #2 aresetn = 1'b0;
        tick();
        total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else passed++;
        total++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b want 0", wr_err); else passed++;
        total++; if (cfg_update !== 1'b0) $display("FAIL reset_cfg_update: got %b want 0", cfg_update); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending); else passed++;
        total++; if (apply_count !== 16'd0) $display("FAIL reset_apply_count: got %h want 0", apply_count); else passed++;
        total++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
        total++; if (cfg_data !== '0) $display("FAIL reset_cfg_data: got nonzero want 0"); else passed++;
        aresetn = 1'b1;
        total++; if (wr_ready !== 1'b0) $display("FAIL reset_release_ready_early: got %b want 0", wr_ready); else passed++;
        tick();
        total++; if (wr_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", wr_ready); else passed++;
    endtask

    task automatic test_async_commit();
        write_word(5'd0, 32'h12345678, 4'hF);
        total++; if (wr_err !== 1'b0) $display("FAIL async_no_err: got %b want 0", wr_err); else passed++;
        sync_mode  = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        total++; if (cfg_update !== 1'b0) $display("FAIL async_early_update: got %b want 0", cfg_update); else passed++;
        total++; if (wr_ready !== 1'b0) $display("FAIL async_apply_ready: got %b want 0", wr_ready); else passed++;
        tick();
        total++; if (cfg_update !== 1'b1) $display("FAIL async_update: got %b want 1", cfg_update); else passed++;
        total++; if (cfg_data[31:0] !== 32'h12345678) $display("FAIL async_word0: got %h want 12345678", cfg_data[31:0]); else passed++;
        total++; if (apply_count !== 16'd1) $display("FAIL async_count: got %0d want 1", apply_count); else passed++;
        tick();
        total++; if (cfg_update !== 1'b0) $display("FAIL async_update_width: got %b want 0", cfg_update); else passed++;
        total++; if (wr_ready !== 1'b1) $display("FAIL async_ready_back: got %b want 1", wr_ready); else passed++;
    endtask

    task automatic test_write_with_commit();
        wr_valid = 1'b1; wr_addr = 5'd2; wr_data = 32'hCAFEF00D; wr_strb = 4'hF;
        commit_req = 1'b1;
        tick();
        wr_valid = 1'b0; commit_req = 1'b0;
        tick();
        total++; if (cfg_update !== 1'b1) $display("FAIL same_cycle_update: got %b want 1", cfg_update); else passed++;
        total++; if (cfg_data[95:64] !== 32'hCAFEF00D) $display("FAIL same_cycle_word2: got %h want cafef00d", cfg_data[95:64]); else passed++;
        total++; if (apply_count !== 16'd2) $display("FAIL same_cycle_count: got %0d want 2", apply_count); else passed++;
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        write_word(5'd1, 32'hFFFFFFFF, 4'hF);
        write_word(5'd1, 32'h00000000, 4'h2);
        read_word(1'b1, 5'd1, d);
        total++; if (d !== 32'hFFFF00FF) $display("FAIL strobe_shadow: got %h want ffff00ff", d); else passed++;
        read_word(1'b0, 5'd1, d);
        total++; if (d !== 32'h0) $display("FAIL strobe_active: got %h want 0", d); else passed++;
        write_word(5'd5, 32'hA1B2C3D4, 4'h9);
        read_word(1'b1, 5'd5, d);
        total++; if (d !== 32'hA10000D4) $display("FAIL strobe_mixed: got %h want a10000d4", d); else passed++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        write_word(5'd26, 32'hDEADBEEF, 4'hF);
        total++; if (wr_err !== 1'b1) $display("FAIL oor_err_pulse: got %b want 1", wr_err); else passed++;
        tick();
        total++; if (wr_err !== 1'b0) $display("FAIL oor_err_width: got %b want 0", wr_err); else passed++;
        read_word(1'b1, 5'd0, d);
        total++; if (d !== 32'h12345678) $display("FAIL oor_shadow0: got %h want 12345678", d); else passed++;
        read_word(1'b1, 5'd1, d);
        total++; if (d !== 32'hFFFF00FF) $display("FAIL oor_shadow1: got %h want ffff00ff", d); else passed++;
        read_word(1'b0, 5'd0, d);
        total++; if (d !== 32'h12345678) $display("FAIL oor_active0: got %h want 12345678", d); else passed++;
        read_word(1'b1, 5'd26, d);
        total++; if (d !== 32'h0) $display("FAIL oor_read26: got %h want 0", d); else passed++;
        read_word(1'b0, 5'd31, d);
        total++; if (d !== 32'h0) $display("FAIL oor_read31: got %h want 0", d); else passed++;
    endtask

    task automatic test_sync_commit();
        int pend_cycles = 0;
        int bad = 0;
        write_word(5'd3, 32'hAAAA5555, 4'hF);
        sync_mode   = 1'b1;
        commit_req  = 1'b1;
        update_tick = 1'b1;
        tick();
        commit_req  = 1'b0;
        update_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pending === 1'b1) pend_cycles++;
            if (wr_ready !== 1'b0 || cfg_data[127:96] !== 32'h0 || cfg_update !== 1'b0) bad++;
            if (i == 9) update_tick = 1'b1;
            tick();
        end
        update_tick = 1'b0;
        total++; if (pend_cycles != 10) $display("FAIL sync_pending_cycles: got %0d want 10", pend_cycles); else passed++;
        total++; if (bad != 0) $display("FAIL sync_hold: got %0d bad cycles want 0", bad); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL sync_apply_pending: got %b want 0", pending); else passed++;
        total++; if (cfg_data[127:96] !== 32'h0) $display("FAIL sync_apply_word3: got %h want 0", cfg_data[127:96]); else passed++;
        total++; if (cfg_update !== 1'b0) $display("FAIL sync_apply_update: got %b want 0", cfg_update); else passed++;
        tick();
        total++; if (cfg_update !== 1'b1) $display("FAIL sync_update: got %b want 1", cfg_update); else passed++;
        total++; if (cfg_data[127:96] !== 32'hAAAA5555) $display("FAIL sync_word3: got %h want aaaa5555", cfg_data[127:96]); else passed++;
        total++; if (apply_count !== 16'd3) $display("FAIL sync_count: got %0d want 3", apply_count); else passed++;
        sync_mode = 1'b0;
    endtask

    task automatic test_abort();
        int pulses = 0;
        logic [31:0] d;
        write_word(5'd4, 32'h11112222, 4'hF);
        sync_mode  = 1'b1;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        tick();
        commit_abort = 1'b1;
        update_tick  = 1'b1;
        tick();
        commit_abort = 1'b0;
        update_tick  = 1'b0;
        total++; if (pending !== 1'b0) $display("FAIL abort_pending: got %b want 0", pending); else passed++;
        total++; if (wr_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", wr_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (cfg_update === 1'b1) pulses++;
            tick();
        end
        total++; if (pulses != 0) $display("FAIL abort_pulses: got %0d want 0", pulses); else passed++;
        total++; if (apply_count !== 16'd3) $display("FAIL abort_count: got %0d want 3", apply_count); else passed++;
        read_word(1'b0, 5'd4, d);
        total++; if (d !== 32'h0) $display("FAIL abort_active4: got %h want 0", d); else passed++;

        sync_mode    = 1'b0;
        commit_req   = 1'b1;
        commit_abort = 1'b1;
        tick();
        commit_req   = 1'b0;
        commit_abort = 1'b0;
        tick();
        total++; if (cfg_update !== 1'b1) $display("FAIL idle_abort_update: got %b want 1", cfg_update); else passed++;
        total++; if (apply_count !== 16'd4) $display("FAIL idle_abort_count: got %0d want 4", apply_count); else passed++;
        total++; if (cfg_data[159:128] !== 32'h11112222) $display("FAIL idle_abort_word4: got %h want 11112222", cfg_data[159:128]); else passed++;

        sync_mode  = 1'b1;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        total++; if (pending !== 1'b1) $display("FAIL rst_pend_entry: got %b want 1", pending); else passed++;
        aresetn = 1'b0;
        #1;
        total++; if (cfg_data !== '0) $display("FAIL rst_pend_cfg_data: got nonzero want 0"); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL rst_pend_pending: got %b want 0", pending); else passed++;
        total++; if (apply_count !== 16'd0) $display("FAIL rst_pend_count: got %0d want 0", apply_count); else passed++;
        tick();
        aresetn = 1'b1;
        update_tick = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cfg_update === 1'b1) pulses++;
        end
        update_tick = 1'b0;
        sync_mode   = 1'b0;
        total++; if (pulses != 0) $display("FAIL rst_pend_pulses: got %0d want 0", pulses); else passed++;
        read_word(1'b1, 5'd0, d);
        total++; if (d !== 32'h0) $display("FAIL rst_shadow_cleared: got %h want 0", d); else passed++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        sync_mode  = 1'b0;
        commit_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cfg_update === 1'b1) pulses++;
        end
        commit_req = 1'b0;
        total++; if (pulses != 100) $display("FAIL b2b_pulses: got %0d want 100", pulses); else passed++;
        total++; if (apply_count !== 16'd100) $display("FAIL b2b_count: got %0d want 100", apply_count); else passed++;
    endtask

    task automatic test_wrap();
        tick();
        // Start near the top of the count range so the wrap is reached quickly.
        dut.apply_cnt = 16'hFFFD;
        commit_req = 1'b1;
        tick(); tick();
        total++; if (apply_count !== 16'hFFFE) $display("FAIL wrap_fffe: got %h want fffe", apply_count); else passed++;
        tick(); tick();
        total++; if (apply_count !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", apply_count); else passed++;
        tick(); tick();
        commit_req = 1'b0;
        total++; if (apply_count !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", apply_count); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_async_commit();
        test_write_with_commit();
        test_strobe();
        test_out_of_range();
        test_sync_commit();
        test_abort();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
